register_file_mp: RTL
=====================

// Module: register_file_mp
// PURPOSE
//  Multi-ported, parametrised general-purpose register file with integrated scoreboard.
//  Sits between decode/issue and the ALUs: NUM_READ registered read ports feed operands,
//  NUM_WRITE writeback ports retire results, one reserve port marks in-flight destinations.
//  Adds r0-hardwired-zero, write-to-read bypass, per-register busy tracking and reset.
// PARAMETERS
//  BUS_DATA_WIDTH  64  register width in bits
//  NUM_REGS        32  number of architectural registers (>=2)
//  NUM_READ        2   read ports (1..4)
//  NUM_WRITE       1   writeback ports (1..2)
//  ADDR_W  $clog2(NUM_REGS)  derived, localparam, not overridable
// PORTS
//  clk       in   1                        clock, all logic on posedge
//  reset     in   1                        synchronous, active-high
//  rd_addr   in   NUM_READ*ADDR_W          read addresses, port i at [i*ADDR_W +: ADDR_W]
//  rd_data   out  NUM_READ*BUS_DATA_WIDTH  registered read data, port i slice i
//  rd_busy   out  NUM_READ                 registered: source register still reserved
//  wr_en     in   NUM_WRITE                writeback strobe per port
//  wr_addr   in   NUM_WRITE*ADDR_W         writeback destination
//  wr_data   in   NUM_WRITE*BUS_DATA_WIDTH writeback value
//  rsv_en    in   1                        issue: mark rsv_addr busy
//  rsv_addr  in   ADDR_W                   destination being reserved
//  busy      out  NUM_REGS                 current scoreboard state (bit 0 always 0)
// BEHAVIOUR
//  - Reset: all registers <= 0, busy <= 0, rd_data <= 0, rd_busy <= 0. Reset in a cycle
//    overrides any write/reserve in that cycle; next cycle operates normally.
//  - Read latency 1: rd_data sampled at edge N reflects rd_addr presented in cycle N-1.
//  - Bypass (write-first): if wr_en[j] && wr_addr[j]==rd_addr[i] in the same cycle,
//    rd_data[i] gets wr_data[j] at the next edge, not the stale array value.
//  - r0: reads return 0; writes and reservations to address 0 are ignored (no bypass).
//  - Address >= NUM_REGS (non-power-of-2 NUM_REGS): reads 0, writes/reserves ignored.
//  - Two write ports same address same cycle: highest port index wins, for array and bypass.
//  - Scoreboard per register r: set on rsv_en&&rsv_addr==r; cleared on any wr_en to r.
//    Simultaneous reserve and write to r: busy stays 1 (new reservation supersedes
//    retiring writer); data is still written.
//  - rd_busy[i] at edge N = post-update busy state of rd_addr[i] from cycle N-1,
//    i.e. a same-cycle writeback clears it, a same-cycle reserve sets it.
//  - busy output is the registered state, updated each edge; no combinational path
//    from inputs to any output.
//  - No handshake/backpressure: every request accepted every cycle; stall decisions
//    belong to the issue stage using rd_busy/busy.
// STRUCTURE
//  - regfile_pkg: ADDR_W helper function, typedef logic [BUS_DATA_WIDTH-1:0] reg_word_t,
//    constant REG_ZERO = '0.
//  - Sub-module regfile_scoreboard: NUM_REGS busy bits, reserve/clear logic, r0 masking.
//  - Top: storage array, write-port priority resolve, per-read-port bypass mux, output regs.
// TESTING
//  1. Reset then read all 32 regs on 2 ports -> rd_data=0, rd_busy=0, busy=0.
//  2. Write r5=0xDEAD_BEEF at edge N, read r5 cycle N+1 -> rd_data=0xDEADBEEF at N+2.
//  3. Same-cycle write r7=0x1234 and read r7 -> rd_data=0x1234 next edge (bypass).
//  4. Write r0=0xFFFF, rsv r0, read r0 -> rd_data=0, busy[0]=0.
//  5. NUM_WRITE=2: both ports write r3 (0xAA, 0xBB) -> r3 reads 0xBB.
//  6. rsv r9 -> busy[9]=1, rd_busy=1; wr r9 + rsv r9 same cycle -> busy[9] stays 1;
//     wr r9 alone -> busy[9]=0; assert reset mid-sequence -> all busy/data 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-ported register file and its scoreboard.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_word_t;

  localparam reg_word_t REG_ZERO = '0;

  // Address width needed to name every register; never narrower than one bit.
  function automatic int addr_width(input int num_regs);
    return (num_regs > 2) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by the issue-stage reserve, cleared by any writeback.
// r0 can never be busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic [NUM_REGS-1:0] clr,
  output logic [NUM_REGS-1:0] busy,
  output logic [NUM_REGS-1:0] busy_next
);

  // A reserve is applied after the clear, so a new reservation survives a retiring writer.
  always_comb begin
    busy_next = busy & ~clr;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_next[r] = busy_next[r] | (rsv_en && (rsv_addr == ADDR_W'(r)));
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= {NUM_REGS{1'b0}};
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported register file with write-first bypass, hardwired-zero r0,
// registered read ports and an integrated busy scoreboard.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int  BUS_DATA_WIDTH = 64,
  parameter int  NUM_REGS       = 32,
  parameter int  NUM_READ       = 2,
  parameter int  NUM_WRITE      = 1,
  localparam int ADDR_W         = addr_width(NUM_REGS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_READ*ADDR_W-1:0]          rd_addr,
  output logic [NUM_READ*BUS_DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ-1:0]                 rd_busy,
  input  logic [NUM_WRITE-1:0]                wr_en,
  input  logic [NUM_WRITE*ADDR_W-1:0]         wr_addr,
  input  logic [NUM_WRITE*BUS_DATA_WIDTH-1:0] wr_data,
  input  logic                                rsv_en,
  input  logic [ADDR_W-1:0]                   rsv_addr,
  output logic [NUM_REGS-1:0]                 busy
);

  logic [BUS_DATA_WIDTH-1:0]          mem [NUM_REGS];
  logic [NUM_WRITE-1:0]               wr_valid;
  logic [NUM_REGS-1:0]                clr;
  logic [NUM_REGS-1:0]                busy_next;
  logic [NUM_READ*BUS_DATA_WIDTH-1:0] rd_data_next;
  logic [NUM_READ-1:0]                rd_busy_next;

  // Real storage only: excludes r0 and addresses beyond NUM_REGS.
  function automatic logic reg_valid(input logic [ADDR_W-1:0] a);
    return (a != {ADDR_W{1'b0}}) && (int'(a) < NUM_REGS);
  endfunction

  // Qualify writes and build the per-register scoreboard clear vector.
  always_comb begin
    clr = {NUM_REGS{1'b0}};
    for (int j = 0; j < NUM_WRITE; j++) begin
      wr_valid[j] = wr_en[j] && reg_valid(wr_addr[j*ADDR_W +: ADDR_W]);
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        clr[r] = clr[r] | (wr_valid[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r)));
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .clr       (clr),
    .busy      (busy),
    .busy_next (busy_next)
  );

  // Storage array; later write ports are applied last so the highest index wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem[r] <= BUS_DATA_WIDTH'(REG_ZERO);
      end
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_valid[j]) begin
          mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        end
      end
    end
  end

  // Per-port read mux with write-first bypass, scanned in port order for the same priority.
  always_comb begin
    rd_data_next = {(NUM_READ*BUS_DATA_WIDTH){1'b0}};
    rd_busy_next = {NUM_READ{1'b0}};
    for (int i = 0; i < NUM_READ; i++) begin : g_read
      logic [ADDR_W-1:0]         a;
      logic [BUS_DATA_WIDTH-1:0] word;
      a    = rd_addr[i*ADDR_W +: ADDR_W];
      word = reg_valid(a) ? mem[a] : BUS_DATA_WIDTH'(REG_ZERO);
      for (int j = 0; j < NUM_WRITE; j++) begin
        word = (wr_valid[j] && (wr_addr[j*ADDR_W +: ADDR_W] == a)) ?
               wr_data[j*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] : word;
      end
      rd_data_next[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = word;
      rd_busy_next[i] = reg_valid(a) ? busy_next[a] : 1'b0;
    end
  end

  // Output registers: no combinational path from inputs to outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= {(NUM_READ*BUS_DATA_WIDTH){1'b0}};
      rd_busy <= {NUM_READ{1'b0}};
    end else begin
      rd_data <= rd_data_next;
      rd_busy <= rd_busy_next;
    end
  end

endmodule
